// File: rtl/am_search_top2.sv
// am_search_top2
// ---------------------------------------------------------------------------
// Associative-memory search engine. On an accepted start it captures a query
// hypervector and scans up to NUM_CLASSES_MAX class hypervectors stored in AM
// SRAM at base + i*ADDR_STRIDE. Each class is scored by popcount(query & class).
// The best and second-best scores are tracked. The winner, its score, the
// best/second margin and a threshold-reject flag are returned over valid/ready.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_i            start request, honoured only while idle
//   query_hv_i         query hypervector (captured on start)
//   num_classes_i      number of classes to scan (captured on start)
//   am_addr_base_i     AM address of class 0 (captured on start)
//   min_score_i        reject threshold (captured on start)
//   busy_o             search in progress or result not yet consumed
//   am_ren_o/addr_o    AM read request, one class per cycle
//   am_rdata_i         AM read data, RD_LATENCY cycles after the request
//   valid_o/ready_i    result handshake
//   class_o, score_o   winning class index and score
//   margin_o           best score minus second-best score
//   reject_o           best below threshold, or zero classes scanned
// ---------------------------------------------------------------------------
module am_search_top2 #(
  parameter int HV_LENGTH       = 1024,
  parameter int AM_ADDR_WIDTH   = 13,
  parameter int ADDR_STRIDE     = 256,
  parameter int NUM_CLASSES_MAX = 32,
  parameter int RD_LATENCY      = 1,
  parameter int CLASS_W         = $clog2(NUM_CLASSES_MAX),
  parameter int CNT_WIDTH       = $clog2(HV_LENGTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [HV_LENGTH-1:0]     query_hv_i,
  input  logic [CLASS_W:0]         num_classes_i,
  input  logic [AM_ADDR_WIDTH-1:0] am_addr_base_i,
  input  logic [CNT_WIDTH-1:0]     min_score_i,
  output logic                     busy_o,
  output logic                     am_ren_o,
  output logic [AM_ADDR_WIDTH-1:0] am_addr_o,
  input  logic [HV_LENGTH-1:0]     am_rdata_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [CLASS_W-1:0]       class_o,
  output logic [CNT_WIDTH-1:0]     score_o,
  output logic [CNT_WIDTH-1:0]     margin_o,
  output logic                     reject_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam int DRAIN_W = $clog2(RD_LATENCY + 1);

  // Sparse similarity: number of set bits in the ANDed vectors.
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [HV_LENGTH-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int k = 0; k < HV_LENGTH; k++) begin
      c = c + CNT_WIDTH'(v[k]);
    end
    return c;
  endfunction

  // Control / captured-request registers
  logic [1:0]               state_q,  state_d;
  logic [CLASS_W-1:0]       idx_q,    idx_d;
  logic [AM_ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic                     ren_q,    ren_d;
  logic [DRAIN_W-1:0]       drain_q,  drain_d;
  logic                     busy_q,   busy_d;
  logic [HV_LENGTH-1:0]     query_q,  query_d;
  logic [CLASS_W:0]         num_q,    num_d;
  logic [CNT_WIDTH-1:0]     min_q,    min_d;
  logic                     clr_best_s;

  // Result registers
  logic                     valid_q,  valid_d;
  logic [CLASS_W-1:0]       class_q,  class_d;
  logic [CNT_WIDTH-1:0]     score_q,  score_d;
  logic [CNT_WIDTH-1:0]     margin_q, margin_d;
  logic                     reject_q, reject_d;

  // Read-return tracking: a valid bit and class index travel with each read
  // so that the stage aligned with am_rdata_i knows which class it carries.
  logic [RD_LATENCY-1:0]    rd_vld_q;
  logic [CLASS_W-1:0]       rd_idx_q [RD_LATENCY];

  // Popcount stage
  logic                     pc_vld_q;
  logic [CNT_WIDTH-1:0]     pc_q;
  logic [CLASS_W-1:0]       pc_idx_q;

  // Compare stage
  logic [CNT_WIDTH-1:0]     best_q;
  logic [CNT_WIDTH-1:0]     second_q;
  logic [CLASS_W-1:0]       best_idx_q;

  logic [CLASS_W:0]         last_idx_s;
  assign last_idx_s = num_q - (CLASS_W + 1)'(1);

  // FSM, read issue and result next-state logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    ren_d      = ren_q;
    drain_d    = drain_q;
    busy_d     = busy_q;
    query_d    = query_q;
    num_d      = num_q;
    min_d      = min_q;
    clr_best_s = 1'b0;
    valid_d    = valid_q;
    class_d    = class_q;
    score_d    = score_q;
    margin_d   = margin_q;
    reject_d   = reject_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          query_d    = query_hv_i;
          num_d      = num_classes_i;
          min_d      = min_score_i;
          idx_d      = '0;
          addr_d     = am_addr_base_i;
          busy_d     = 1'b1;
          clr_best_s = 1'b1;
          if (num_classes_i != '0) begin
            // Class 0 is requested in the very first busy cycle.
            state_d = S_ISSUE;
            ren_d   = 1'b1;
          end else begin
            state_d = S_RESULT;
            ren_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if ({1'b0, idx_q} == last_idx_s) begin
          ren_d   = 1'b0;
          drain_d = DRAIN_W'(RD_LATENCY);
          state_d = S_DRAIN;
        end else begin
          idx_d  = idx_q + CLASS_W'(1);
          // Wraps modulo 2^AM_ADDR_WIDTH by truncation.
          addr_d = addr_q + AM_ADDR_WIDTH'(ADDR_STRIDE);
        end
      end
      S_DRAIN: begin
        // The last compare lands on the same edge that leaves DRAIN.
        if (drain_q == '0) begin
          state_d = S_RESULT;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_RESULT: begin
        if (!valid_q) begin
          valid_d  = 1'b1;
          class_d  = best_idx_q;
          score_d  = best_q;
          margin_d = best_q - second_q;
          reject_d = (num_q == '0) || (best_q < min_q);
        end else if (ready_i) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ren_d   = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Control, captured-request and result registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      ren_q    <= 1'b0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      query_q  <= '0;
      num_q    <= '0;
      min_q    <= '0;
      valid_q  <= 1'b0;
      class_q  <= '0;
      score_q  <= '0;
      margin_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      ren_q    <= ren_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      query_q  <= query_d;
      num_q    <= num_d;
      min_q    <= min_d;
      valid_q  <= valid_d;
      class_q  <= class_d;
      score_q  <= score_d;
      margin_q <= margin_d;
      reject_q <= reject_d;
    end
  end

  // Read-return alignment shift register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_vld_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        rd_idx_q[k] <= '0;
      end
    end else begin
      rd_vld_q[0] <= ren_q;
      rd_idx_q[0] <= idx_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
        rd_vld_q[k] <= rd_vld_q[k-1];
        rd_idx_q[k] <= rd_idx_q[k-1];
      end
    end
  end

  // AND/popcount stage on the returning class vector
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_vld_q <= 1'b0;
      pc_q     <= '0;
      pc_idx_q <= '0;
    end else begin
      pc_vld_q <= rd_vld_q[RD_LATENCY-1];
      pc_q     <= popcount(query_q & am_rdata_i);
      pc_idx_q <= rd_idx_q[RD_LATENCY-1];
    end
  end

  // Best / second-best tracking; strict compares keep the lower index on ties
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
    end else if (clr_best_s) begin
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
    end else if (pc_vld_q) begin
      if (pc_q > best_q) begin
        second_q   <= best_q;
        best_q     <= pc_q;
        best_idx_q <= pc_idx_q;
      end else if (pc_q > second_q) begin
        second_q <= pc_q;
      end
    end
  end

  assign busy_o    = busy_q;
  assign am_ren_o  = ren_q;
  assign am_addr_o = addr_q;
  assign valid_o   = valid_q;
  assign class_o   = class_q;
  assign score_o   = score_q;
  assign margin_o  = margin_q;
  assign reject_o  = reject_q;

endmodule

// File: tb/tb_am_search_top2.sv
module tb_am_search_top2;
  localparam int HVL  = 1024;
  localparam int AW   = 13;
  localparam int CW   = 5;
  localparam int CNTW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start1, start3, ready;
  logic [HVL-1:0]  query;
  logic [CW:0]     num;
  logic [AW-1:0]   base;
  logic [CNTW-1:0] min_s;

  logic            busy1, ren1, valid1, reject1, busy3, ren3, valid3, reject3;
  logic [AW-1:0]   addr1, addr3;
  logic [HVL-1:0]  rdata1, rdata3;
  logic [CW-1:0]   class1, class3;
  logic [CNTW-1:0] score1, margin1, score3, margin3;

  am_search_top2 #(.RD_LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .query_hv_i(query),
    .num_classes_i(num), .am_addr_base_i(base), .min_score_i(min_s),
    .busy_o(busy1), .am_ren_o(ren1), .am_addr_o(addr1), .am_rdata_i(rdata1),
    .valid_o(valid1), .ready_i(ready), .class_o(class1), .score_o(score1),
    .margin_o(margin1), .reject_o(reject1));

  am_search_top2 #(.RD_LATENCY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .query_hv_i(query),
    .num_classes_i(num), .am_addr_base_i(base), .min_score_i(min_s),
    .busy_o(busy3), .am_ren_o(ren3), .am_addr_o(addr3), .am_rdata_i(rdata3),
    .valid_o(valid3), .ready_i(ready), .class_o(class3), .score_o(score3),
    .margin_o(margin3), .reject_o(reject3));

  int checks = 0;
  int failures = 0;

  // AM contents keyed by address; unloaded addresses and idle cycles return
  // all-ones so a misaligned capture produces a visibly wrong score.
  logic [HVL-1:0] mem [int];
  int rd1[$];
  int rd3[$];
  logic [HVL-1:0] p3a, p3b, p3c, d1;

  function automatic logic [HVL-1:0] rdval(input logic en, input logic [AW-1:0] a);
    if (en && mem.exists(int'(a))) return mem[int'(a)];
    return '1;
  endfunction

  always @(posedge clk) begin
    d1  <= rdval(ren1, addr1);
    p3a <= rdval(ren3, addr3);
    p3b <= p3a;
    p3c <= p3b;
    if (ren1) rd1.push_back(int'(addr1));
    if (ren3) rd3.push_back(int'(addr3));
  end
  assign rdata1 = d1;
  assign rdata3 = p3c;

  // Class vector scoring exactly k against the query (low 512 bits set);
  // bits 1000..1023 are set too but lie outside the query.
  function automatic logic [HVL-1:0] mk(input int k);
    logic [HVL-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    for (int i = 1000; i < HVL; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start on one instance and count cycles until its valid_o rises.
  task automatic run(input int which, output int lat);
    rd1.delete();
    rd3.delete();
    ready = 1'b0;
    if (which == 1) start1 = 1'b1; else start3 = 1'b1;
    tick();
    start1 = 1'b0;
    start3 = 1'b0;
    lat = 1;
    while (!((which == 1) ? valid1 : valid3) && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake1();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("hs_valid_drop", valid1, 1'b0);
    chk("hs_busy_drop", busy1, 1'b0);
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    mem.delete();
    mem[32'h100] = mk(a);
    mem[32'h200] = mk(b);
    mem[32'h300] = mk(c);
    mem[32'h400] = mk(d);
  endtask

  initial begin
    int lat;
    int seen;
    int found;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; ready = 1'b0;
    num = '0; base = '0; min_s = '0;
    query = '0;
    for (int i = 0; i < 512; i++) query[i] = 1'b1;
    tick();
    tick();
    chk("rst_ctrl", {valid1, busy1, ren1, reject1}, 4'b0000);
    chk("rst_data", {class1, score1, margin1}, 27'd0);
    chk("rst_ctrl3", {valid3, busy3, ren3}, 3'b000);
    rst_n = 1'b1;
    tick();

    // Basic search: class 2 wins with 40 over 30
    load4(10, 20, 40, 30);
    base = 13'h100; num = 6'd4; min_s = 11'd0;
    run(1, lat);
    chk("t1_latency", lat, 8);
    chk("t1_class", class1, 2);
    chk("t1_score", score1, 40);
    chk("t1_margin", margin1, 10);
    chk("t1_reject", reject1, 1'b0);
    chk("t1_busy", busy1, 1'b1);
    chk("t1_nreads", rd1.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t1_addr", (i < rd1.size()) ? rd1[i] : -1, 32'h100 * (i + 1));
    handshake1();

    // Tie: classes 1 and 3 both 25, lower index wins
    load4(5, 25, 5, 25);
    run(1, lat);
    chk("tie_class", class1, 1);
    chk("tie_score", score1, 25);
    chk("tie_margin", margin1, 0);
    handshake1();

    // Threshold reject, winner still reported
    load4(10, 20, 40, 30);
    min_s = 11'd50;
    run(1, lat);
    chk("rej_flag", reject1, 1'b1);
    chk("rej_class", class1, 2);
    chk("rej_score", score1, 40);
    handshake1();

    // Zero classes: short path, no reads
    num = 6'd0;
    run(1, lat);
    chk("zero_latency", lat, 2);
    chk("zero_reject", reject1, 1'b1);
    chk("zero_result", {class1, score1, margin1}, 27'd0);
    chk("zero_nreads", rd1.size(), 0);
    handshake1();

    // Backpressure with a stray start while busy
    num = 6'd4; min_s = 11'd0;
    run(1, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("bp_hold", {valid1, class1, score1, margin1, reject1}, {1'b1, 5'd2, 11'd40, 11'd10, 1'b0});
    end
    handshake1();
    tick();
    tick();
    chk("bp_nreads", rd1.size(), 4);
    chk("bp_idle", {busy1, ren1, valid1}, 3'b000);

    // Reset mid-issue at class 2 of 8
    mem.delete();
    for (int i = 0; i < 8; i++) mem[32'h100 * (i + 1)] = mk(11 + i);
    num = 6'd8;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (ren1 && addr1 == 13'h300) found = 1;
      else tick();
    end
    chk("rs_reach_cls2", found, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rs_abort", {ren1, busy1, valid1}, 3'b000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid1 || ren1) seen = 1;
    end
    chk("rs_no_valid", seen, 0);
    run(1, lat);
    chk("rs_latency", lat, 12);
    chk("rs_result", {class1, score1, margin1, reject1}, {5'd7, 11'd18, 11'd1, 1'b0});
    chk("rs_nreads", rd1.size(), 8);
    handshake1();

    // Address wrap with RD_LATENCY = 3
    mem.delete();
    mem[32'h1F00] = mk(7);
    mem[32'h0000] = mk(33);
    mem[32'h0100] = mk(12);
    base = 13'h1F00; num = 6'd3;
    run(3, lat);
    chk("wr_latency", lat, 9);
    chk("wr_result", {class3, score3, margin3, reject3}, {5'd1, 11'd33, 11'd21, 1'b0});
    chk("wr_nreads", rd3.size(), 3);
    chk("wr_addr0", (rd3.size() > 0) ? rd3[0] : -1, 32'h1F00);
    chk("wr_addr1", (rd3.size() > 1) ? rd3[1] : -1, 32'h0000);
    chk("wr_addr2", (rd3.size() > 2) ? rd3[2] : -1, 32'h0100);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("wr_hs", {valid3, busy3}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/am_search_top2.md
Name: am_search_top2

Overview:
- Parametrised successor to the associative-memory search block.
- Walks up to NUM_CLASSES_MAX class hypervectors stored at a programmable base and stride in AM SRAM.
- Scores each class with the sparse AND-popcount similarity against a captured query, and tracks both the best and second-best scores.
- Returns class index, score, confidence margin and a threshold-reject flag over a valid/ready handshake. It sits between the encoder and the accelerator result register.

Parameters:
HV_LENGTH, 1024, hypervector width in bits
AM_ADDR_WIDTH, 13, AM SRAM address width
ADDR_STRIDE, 256, address increment between consecutive class vectors
NUM_CLASSES_MAX, 32, maximum class count; CLASS_W = $clog2(NUM_CLASSES_MAX)
RD_LATENCY, 1, AM SRAM cycles from am_ren_o/am_addr_o to am_rdata_i valid (1..3)
CNT_WIDTH, $clog2(HV_LENGTH+1), score width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
start_i  in  1  start a search; sampled only in IDLE
query_hv_i  in  HV_LENGTH  encoded query; captured on accepted start
num_classes_i  in  CLASS_W+1  classes to scan; captured on accepted start
am_addr_base_i  in  AM_ADDR_WIDTH  address of class 0; captured on accepted start
min_score_i  in  CNT_WIDTH  reject threshold; captured on accepted start
busy_o  out  1  high from the cycle after an accepted start until the result is consumed
am_ren_o  out  1  AM read enable
am_addr_o  out  AM_ADDR_WIDTH  AM read address
am_rdata_i  in  HV_LENGTH  AM read data
valid_o  out  1  result valid
ready_i  in  1  result consumer ready
class_o  out  CLASS_W  winning class index
score_o  out  CNT_WIDTH  winning score
margin_o  out  CNT_WIDTH  best minus second-best score
reject_o  out  1  best score below threshold, or no classes scanned

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: all outputs 0; state IDLE; internal counters and scores 0. Asserting reset mid-search aborts on the next edge: no further am_ren_o, and no valid_o.
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE -> ISSUE on start_i with num_classes_i != 0.
  - Captures all inputs; read index i = 0; best = second = 0; best_idx = 0.
- IDLE -> RESULT on start_i with num_classes_i == 0.
  - Result: class 0, score 0, margin 0, reject 1. No AM reads are issued.
- ISSUE: one read per cycle. am_ren_o = 1, am_addr_o = base + i*ADDR_STRIDE.
  - Address arithmetic is modulo 2^AM_ADDR_WIDTH; wrap is allowed and not flagged.
  - After issuing index num_classes-1, go to DRAIN.
- Read pipeline: a read issued at cycle t returns data at t+RD_LATENCY.
  - and/popcount is registered at t+RD_LATENCY+1, with its class index carried alongside.
  - Compare/update happens at t+RD_LATENCY+2. Throughput is one class per cycle.
- Compare rule, with s the incoming score:
  - s > best: second <= best, best <= s, best_idx <= idx.
  - Else s > second: second <= s.
  - Ties keep the lower index, since the comparison is strict.
- DRAIN: wait until the last score is compared, i.e. RD_LATENCY+2 cycles after the last issue, then go to RESULT.
- RESULT: valid_o = 1, with class_o = best_idx, score_o = best, margin_o = best - second, reject_o = (best < min_score).
  - With one class, second stays 0, so margin = best.
  - Outputs are held stable while valid_o && !ready_i.
  - On valid_o && ready_i -> IDLE. valid_o and busy_o drop the next cycle.
- start_i outside IDLE is ignored. start_i in the same cycle as the handshake completes is also ignored; it must be re-presented once IDLE is reached.
- Latency: from accepted start to first valid_o is N + RD_LATENCY + 3 cycles for N classes.

Test Plan:
- HV_LENGTH=1024, RD_LATENCY=1, base=0x100, 4 classes. Query ANDed with class 2 gives popcount 40; others give 10/20/30 -> am_addr_o sequence 0x100, 0x200, 0x300, 0x400; class_o=2, score_o=40, margin_o=10, reject_o=0; valid_o 8 cycles after start.
- Tie: classes 1 and 3 both score 25, others 5 -> class_o=1, margin_o=0.
- min_score_i=50 with best 40 -> reject_o=1, class_o and score_o still 2/40. Then num_classes_i=0 -> valid_o 2 cycles after start, reject_o=1, no am_ren_o.
- Backpressure: ready_i low for 5 cycles -> outputs stable, valid_o held. start_i pulsed during busy -> ignored, no extra reads.
- Reset: rst_ni low for 1 cycle mid-ISSUE at class 2 of 8 -> next cycle am_ren_o=0, busy_o=0, valid_o never asserts. A new start then runs a clean search with correct result.
- Wrap/latency: base=0x1F00, stride 256, 3 classes, RD_LATENCY=3 -> addresses 0x1F00, 0x0000, 0x0100; result correct; valid_o 9 cycles after start.
